// File: rtl/ov7670_config_seq.sv
// rtl/ov7670_config_seq.sv - OV7670 register-table sequencer driving an SCCB write interface
//
// Walks a synchronous configuration ROM from address 0. Each ROM word is
// {reg[15:8], value[7:0]}. Two words are markers: END_WORD finishes the
// table, and DELAY_WORD waits DELAY_CYCLES clocks before the next entry.
// Any other word is issued as one valid/ready register write.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 one-cycle request to run the table from address 0
//   rom_addr / rom_data   registered ROM address; data valid one clk later
//   sccb_valid/ready      register-write handshake to the SCCB transmitter
//   sccb_reg / sccb_val   register address/value, held while sccb_valid=1
//   busy / done           run in progress / table finished
//
// Build option: define OV7670_CFG_AUTOSTART_EN to start the table on the
// first clock edge after reset without waiting for start.

module ov7670_config_seq #(
  parameter int          DELAY_CYCLES = 240000,
  parameter logic [15:0] END_WORD     = 16'hFFFF,
  parameter logic [15:0] DELAY_WORD   = 16'hFFF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        sccb_valid,
  input  logic        sccb_ready,
  output logic [7:0]  sccb_reg,
  output logic [7:0]  sccb_val,
  output logic        busy,
  output logic        done
);

  localparam int            CW       = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DLY_LOAD = CW'(DELAY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_DELAY,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] dly_cnt;
  logic          go;
  logic          last_addr;
  logic          entering_done;
  logic          is_end, is_delay;

`ifdef OV7670_CFG_AUTOSTART_EN
  // Set by reset, cleared by the first edge: acts as a start pulse on that edge.
  logic auto_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) auto_pend <= 1'b1;
    else        auto_pend <= 1'b0;
  end

  assign go = start | auto_pend;
`else
  assign go = start;
`endif

  assign last_addr     = (rom_addr == 8'hFF);
  assign is_end        = (rom_data == END_WORD);
  assign is_delay      = (rom_data == DELAY_WORD);
  assign entering_done = (state_nxt == S_DONE) && (state != S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (go) state_nxt = S_FETCH;
      S_FETCH:        state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_end)        state_nxt = S_DONE;
        else if (is_delay) state_nxt = S_DELAY;
        else               state_nxt = S_SEND;
      end
      // An entry completed at address 255 ends the table instead of wrapping.
      S_SEND:  if (sccb_ready)        state_nxt = last_addr ? S_DONE : S_FETCH;
      S_DELAY: if (dly_cnt == '0)     state_nxt = last_addr ? S_DONE : S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr   <= 8'h00;
      sccb_valid <= 1'b0;
      sccb_reg   <= 8'h00;
      sccb_val   <= 8'h00;
      dly_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            rom_addr <= 8'h00;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        S_DECODE: begin
          if (is_delay) begin
            dly_cnt <= DLY_LOAD;
          end else if (!is_end) begin
            sccb_reg   <= rom_data[15:8];
            sccb_val   <= rom_data[7:0];
            sccb_valid <= 1'b1;
          end
        end
        S_SEND: begin
          if (sccb_ready) begin
            sccb_valid <= 1'b0;
            if (!last_addr) rom_addr <= rom_addr + 8'd1;
          end
        end
        S_DELAY: begin
          if (dly_cnt == '0) begin
            if (!last_addr) rom_addr <= rom_addr + 8'd1;
          end else begin
            dly_cnt <= dly_cnt - 1'b1;
          end
        end
        default: ;
      endcase

      if (entering_done) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_config_seq.sv
// tb/tb_ov7670_config_seq.sv - self-checking bench for ov7670_config_seq

module tb_ov7670_config_seq;

  localparam int DLY = 16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sccb_valid;
  logic        sccb_ready;
  logic [7:0]  sccb_reg;
  logic [7:0]  sccb_val;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom [256];
  logic [15:0] xq[$];
  logic [15:0] exp_q[$];
  bit          ready_rand = 0;

  ov7670_config_seq #(.DELAY_CYCLES(DLY)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .sccb_valid (sccb_valid),
    .sccb_ready (sccb_ready),
    .sccb_reg   (sccb_reg),
    .sccb_val   (sccb_val),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transfer capture and hold-stability monitor.
  logic       prev_wait = 1'b0;
  logic [7:0] prev_reg, prev_val;
  always @(posedge clk) begin
    if (!rst_n) begin
      prev_wait = 1'b0;
    end else begin
      if (prev_wait) begin
        check("hold_valid", sccb_valid, 1);
        check("hold_regval", {sccb_reg, sccb_val}, {prev_reg, prev_val});
      end
      if (sccb_valid && sccb_ready) xq.push_back({sccb_reg, sccb_val});
      prev_wait = sccb_valid && !sccb_ready;
      prev_reg  = sccb_reg;
      prev_val  = sccb_val;
    end
  end

  initial forever begin
    @(negedge clk);
    if (ready_rand) sccb_ready = 1'($urandom_range(0, 1));
  end

  // Reference: walk the table by its rules. Costs are in cycles after the
  // start edge, assuming sccb_ready is always high.
  task automatic model(output int cost, output int first_v, output int last_addr);
    int a;
    exp_q.delete();
    cost = 0; first_v = -1; a = 0;
    forever begin
      if (rom[a] == 16'hFFFF) begin
        cost += 2;
        break;
      end else if (rom[a] == 16'hFFF0) begin
        cost += 2 + DLY;
      end else begin
        exp_q.push_back(rom[a]);
        if (first_v < 0) first_v = cost + 2;
        cost += 3;
      end
      if (a == 255) break;
      a++;
    end
    last_addr = a;
  endtask

  task automatic run_table(input bit rnd, input int glitch_at, output int cyc, output int first_v);
    xq.delete();
    ready_rand = rnd;
    if (!rnd) sccb_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
    cyc = 0;
    first_v = -1;
    while (cyc < 8000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (sccb_valid && first_v < 0) first_v = cyc;
      start = (cyc == glitch_at);
      if (done) break;
    end
    start = 1'b0;
    ready_rand = 1'b0;
    check("done_reached", done, 1);
    check("busy_at_done", busy, 0);
  endtask

  task automatic compare_xfers(input string tag);
    int bad;
    check({tag, "_count"}, xq.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < xq.size() && i < exp_q.size(); i++)
      if (xq[i] !== exp_q[i]) bad++;
    check({tag, "_data"}, bad, 0);
  endtask

  task automatic fill(input logic [15:0] w);
    for (int i = 0; i < 256; i++) rom[i] = w;
  endtask

  initial begin
    int cyc, fv, m_cost, m_first, m_last, n;
    logic [15:0] w;

    rst_n = 1'b0;
    start = 1'b0;
    sccb_ready = 1'b0;
    fill(16'hFFFF);
    repeat (3) @(negedge clk);
    check("rst_addr", rom_addr, 0);
    check("rst_valid", sccb_valid, 0);
    check("rst_reg", sccb_reg, 0);
    check("rst_val", sccb_val, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_no_start_busy", busy, 0);
    check("idle_no_start_valid", sccb_valid, 0);

    // Single write then end marker.
    fill(16'hFFFF);
    rom[0] = 16'h1280;
    model(m_cost, m_first, m_last);
    run_table(0, -1, cyc, fv);
    compare_xfers("single");
    check("single_cycles", cyc, m_cost);
    check("single_latency", fv, m_first);
    check("single_addr", rom_addr, m_last);

    // Delay marker then a write.
    fill(16'hFFFF);
    rom[0] = 16'hFFF0;
    rom[1] = 16'h1204;
    model(m_cost, m_first, m_last);
    run_table(0, -1, cyc, fv);
    compare_xfers("delay");
    check("delay_cycles", cyc, m_cost);
    check("delay_first_valid", fv, m_first);
    check("delay_addr", rom_addr, m_last);

    // Back-pressure: ready low for 50 cycles.
    fill(16'hFFFF);
    rom[0] = 16'h1180;
    xq.delete();
    sccb_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!sccb_valid && n < 10) begin @(negedge clk); n++; end
    check("bp_valid_seen", sccb_valid, 1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("bp_valid", sccb_valid, 1);
      check("bp_regval", {sccb_reg, sccb_val}, 16'h1180);
    end
    check("bp_no_xfer", xq.size(), 0);
    sccb_ready = 1'b1;
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    check("bp_done", done, 1);
    check("bp_xfer_count", xq.size(), 1);
    if (xq.size() > 0) check("bp_xfer_data", xq[0], 16'h1180);

    // Randomized tables with delay markers and random back-pressure.
    for (int t = 0; t < 4; t++) begin
      for (int a = 0; a < 256; a++) begin
        if ($urandom_range(0, 15) == 0) begin
          rom[a] = 16'hFFF0;
        end else begin
          do w = 16'($urandom); while (w == 16'hFFFF || w == 16'hFFF0);
          rom[a] = w;
        end
      end
      rom[$urandom_range(3, 60)] = 16'hFFFF;
      model(m_cost, m_first, m_last);
      run_table(1, 7, cyc, fv);
      compare_xfers("rand");
      check("rand_addr", rom_addr, m_last);
    end

    // Full table without end marker, start pulsed mid-run, then rerun.
    fill(16'h3A04);
    model(m_cost, m_first, m_last);
    run_table(0, 100, cyc, fv);
    compare_xfers("full");
    check("full_cycles", cyc, m_cost);
    check("full_addr", rom_addr, 255);
    repeat (3) @(negedge clk);
    check("full_stays_done", done, 1);
    run_table(0, -1, cyc, fv);
    compare_xfers("full_rerun");
    check("full_rerun_cycles", cyc, m_cost);

    // Asynchronous reset mid-DELAY.
    fill(16'hFFFF);
    rom[0] = 16'hFFF0;
    rom[1] = 16'h1204;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_delay_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_addr", rom_addr, 0);
    check("arst_valid", sccb_valid, 0);
    check("arst_regval", {sccb_reg, sccb_val}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("arst_idle_busy", busy, 0);
    check("arst_idle_valid", sccb_valid, 0);

    // Asynchronous reset mid-SEND while stalled.
    rom[0] = 16'h55AA;
    sccb_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_send_valid", sccb_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_send_valid", sccb_valid, 0);
    check("arst_send_regval", {sccb_reg, sccb_val}, 16'h0000);
    check("arst_send_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_send_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ov7670_config_seq.md
OV7670_CONFIG_SEQ -- requirements
Module: ov7670_config_seq

Interface
REQ-001 Parameter DELAY_CYCLES, default 240000, SHALL set the clock cycles spent on a ROM delay marker (10 ms at 24 MHz).
REQ-002 Parameter END_WORD, default 16'hFFFF, SHALL be the ROM end-of-table marker.
REQ-003 Parameter DELAY_WORD, default 16'hFFF0, SHALL be the ROM delay marker.
REQ-004 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  one-cycle request to run the table from address 0.
REQ-007 rom_addr  output  8  registered address to the synchronous config ROM.
REQ-008 rom_data  input  16  ROM word {reg[15:8], value[7:0]}, valid one clk after rom_addr changes.
REQ-009 sccb_valid  output  1  register-write request to the SCCB transmitter.
REQ-010 sccb_ready  input  1  SCCB transmitter can accept a request.
REQ-011 sccb_reg  output  8  register address, stable while sccb_valid=1.
REQ-012 sccb_val  output  8  register value, stable while sccb_valid=1.
REQ-013 busy  output  1  high from accepted start until DONE.
REQ-014 done  output  1  high in DONE until the next accepted start.

Function
REQ-015 States SHALL be IDLE, FETCH, DECODE, SEND, DELAY, DONE.
REQ-016 IDLE: on start=1, clear rom_addr to 0, set busy=1, go to FETCH.
REQ-017 FETCH SHALL last exactly one cycle, then go to DECODE.
REQ-018 DECODE SHALL sample rom_data once: END_WORD -> DONE; DELAY_WORD -> DELAY with counter loaded to DELAY_CYCLES-1; otherwise latch sccb_reg/sccb_val and go to SEND.
REQ-019 SEND: sccb_valid=1; a transfer occurs on a cycle with sccb_valid=1 and sccb_ready=1; next cycle sccb_valid=0, rom_addr+1, FETCH.
REQ-020 sccb_valid SHALL NOT drop, nor sccb_reg/sccb_val change, before the transfer, however long sccb_ready stays low.
REQ-021 DELAY: decrement counter each cycle; when counter=0, rom_addr+1, FETCH; total DELAY residency SHALL be exactly DELAY_CYCLES cycles.
REQ-022 Completing an entry at rom_addr=255 (no end marker) SHALL go to DONE, not wrap to 0.
REQ-023 DONE: busy=0, done=1; start=1 SHALL clear done, restart from address 0 as in IDLE.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 Latency from start to first sccb_valid for a normal word at address 0 SHALL be 3 cycles (IDLE->FETCH->DECODE->SEND).
REQ-026 Consecutive normal words SHALL cost 3 cycles plus handshake wait each.

Reset
REQ-027 rst_n=0 SHALL, asynchronously and at any point including mid-SEND or mid-DELAY, force state IDLE, rom_addr=0, sccb_valid=0, sccb_reg=0, sccb_val=0, delay counter=0, busy=0, done=0.
REQ-028 After rst_n rises, no output SHALL change before the first rising clk edge.

Configuration
REQ-029 Macro OV7670_CFG_AUTOSTART_EN defined: after reset release the block SHALL behave as if start=1 on the first clock edge (IDLE->FETCH, busy=1).
REQ-030 Macro OV7670_CFG_AUTOSTART_EN undefined: the block SHALL remain in IDLE until start=1.

Verification
REQ-031 ROM {0:1280, 1:FFFF}, sccb_ready=1, start pulse -> one transfer reg=12 val=80, then done=1, busy=0, rom_addr=1.
REQ-032 ROM {0:FFF0, 1:1204, 2:FFFF}, DELAY_CYCLES=16 -> sccb_valid first high exactly 16 cycles after entering DELAY plus FETCH+DECODE (19 cycles after DELAY entry at latest); reg=12 val=04.
REQ-033 ROM {0:11 80, 1:FFFF}, sccb_ready held 0 for 50 cycles -> sccb_valid=1, reg=11, val=80 constant for all 50 cycles; single transfer when ready=1.
REQ-034 rst_n pulsed low mid-DELAY -> all outputs zero immediately, state IDLE; with AUTOSTART_EN, rom_addr restarts at 0 and busy=1 after first edge.
REQ-035 ROM with no FFFF (all 256 entries 3A04) -> exactly 256 transfers, then done=1; start during run ignored, start after done gives 256 more.
